// File: rtl/isa_pkg.sv
// ISA constants, instruction word layouts and ALU-op helpers shared by the
// instruction encoder and the control decoder.
package isa_pkg;

  localparam int INSTR_W = 16;

  localparam logic [4:0] OP_RTYPE    = 5'b11001;
  localparam logic [2:0] OP_ITYPE_HI = 3'b010;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_ANDN = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    F_ADD  = 2'b00,
    F_SUB  = 2'b01,
    F_XOR  = 2'b10,
    F_ANDN = 2'b11
  } funct_e;

  // Field layouts, MSB first; both occupy exactly INSTR_W bits.
  typedef struct packed {
    logic [4:0] opc;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] rd;
    logic [1:0] f;
  } rtype_t;

  typedef struct packed {
    logic [4:0] opc;
    logic [2:0] rs;
    logic [2:0] rd;
    logic [4:0] imm;
  } itype_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  function automatic logic alu_legal(input logic [3:0] op);
    return op inside {ALU_ADD, ALU_SUB, ALU_XOR, ALU_ANDN};
  endfunction

  function automatic funct_e alu_funct(input logic [3:0] op);
    case (op)
      ALU_SUB:  return F_SUB;
      ALU_XOR:  return F_XOR;
      ALU_ANDN: return F_ANDN;
      default:  return F_ADD;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write channels of the instruction encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              in_itype;
  logic [3:0]        in_alu_op;
  logic [2:0]        in_rs;
  logic [2:0]        in_rt;
  logic [2:0]        in_rd;
  logic [4:0]        in_imm;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [15:0]       out_instr;

  // Master issues micro-op requests and sinks encoded words.
  modport master (
    output in_valid, in_itype, in_alu_op, in_rs, in_rt, in_rd, in_imm, out_ready,
    input  in_ready, out_valid, out_addr, out_instr
  );

  modport slave (
    input  in_valid, in_itype, in_alu_op, in_rs, in_rt, in_rd, in_imm, out_ready,
    output in_ready, out_valid, out_addr, out_instr
  );
endinterface

// File: rtl/instr_fifo.sv
// Small synchronous FIFO with valid/ready on both sides; the read side shows
// the head entry straight from storage registers.
module instr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             full;
  logic             push;
  logic             pop;

  // Extra pointer bit tells full from empty when the indices coincide.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = mem[rd_ptr[PTR_W-1:0]];

  // NOTE: storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// Encodes micro-op requests into 16-bit instruction words and streams them,
// with sequential addresses, to instruction memory through a small FIFO.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              flush,
  instr_encoder_if.slave    bus,
  output logic              illegal,
  output logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done
);
  state_e               state;
  funct_e               funct;
  rtype_t               r_word;
  itype_t               i_word;
  logic [INSTR_W-1:0]   word;
  logic                 legal;
  logic                 accept;
  logic                 push;
  logic                 fifo_wr_ready;
  logic                 fifo_empty;
  logic [ADDR_W-1:0]    addr_q;

  assign legal = alu_legal(bus.in_alu_op);
  assign funct = alu_funct(bus.in_alu_op);

  always_comb begin
    // NOTE: word gets a default before the conditional override, so no latch is inferred.
    r_word = '{opc: OP_RTYPE, rs: bus.in_rs, rt: bus.in_rt, rd: bus.in_rd, f: funct};
    i_word = '{opc: {OP_ITYPE_HI, funct}, rs: bus.in_rs, rd: bus.in_rd, imm: bus.in_imm};
    word   = r_word;
    if (bus.in_itype) word = i_word;
  end

  // Readiness comes only from registered state, never from in_valid.
  assign bus.in_ready = (state == ST_RUN) && fifo_wr_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && legal;
  assign bus.out_addr = addr_q;
  assign busy         = (state != ST_IDLE);

  instr_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (push),
    .wr_ready (fifo_wr_ready),
    .wr_data  (word),
    .rd_valid (bus.out_valid),
    .rd_ready (bus.out_ready),
    .rd_data  (bus.out_instr),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      count   <= '0;
      illegal <= 1'b0;
      done    <= 1'b0;
    end else begin
      illegal <= accept && !legal;
      done    <= 1'b0;

      // Address wraps naturally; the word counter sticks at all-ones.
      if (bus.out_valid && bus.out_ready) begin
        addr_q <= addr_q + 1'b1;
        if (count != '1) count <= count + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_RUN;
            addr_q <= base_addr;
            count  <= '0;
          end
        end
        ST_RUN: begin
          if (flush) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
